// File: rtl/rv_pkg.sv
// RV32I decode constants shared by the ID stage and its register file.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: not applicable.
package rv_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLL   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_SLT   = 4'd8;
    localparam logic [3:0] ALU_SLTU  = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_type_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       illegal;
        logic [3:0] alu_op;
    } ctrl_t;

    // alt picks SUB/SRA; allow_sub is 0 for OP-IMM, where funct3=000 is always ADDI.
    function automatic logic [3:0] alu_from_f3(logic [2:0] f3, logic alt, logic allow_sub);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// Register file: 2 combinational read ports, 1 write port, x0 hardwired to zero.
// Latency: reads are combinational; writes land on the rising clk edge.
// Backpressure: none; optional write-through forwards a same-cycle write to readers.
module regfile #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd
);
    localparam int         IW      = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [5:0] NREGS_W = 6'(NREGS);

    logic [XLEN-1:0] regs [NREGS];
    logic            wr_ok;

    // Indices at or beyond NREGS do not exist: writes are dropped, reads return zero.
    assign wr_ok = we && (wa != 5'd0) && ({1'b0, wa} < NREGS_W);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[wa[IW-1:0]] <= wd;
        end
    end

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ra1 != 5'd0 && {1'b0, ra1} < NREGS_W) rd1 = regs[ra1[IW-1:0]];
        if (ra2 != 5'd0 && {1'b0, ra2} < NREGS_W) rd2 = regs[ra2[IW-1:0]];
        if (BYPASS_EN && wr_ok && wa == ra1) rd1 = wd;
        if (BYPASS_EN && wr_ok && wa == ra2) rd2 = wd;
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: decode, regfile read, load-use detection, ID/EX register.
// Latency: 1 cycle from instr_in to the ID/EX outputs.
// Backpressure: stall holds ID/EX; hazard_stall asks fetch to hold and inserts a bubble.
module id_stage
    import rv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [31:0]     instr_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            stall,
    input  logic            flush,
    output logic            hazard_stall,
    output logic            out_valid,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [3:0]      alu_op,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            alu_src,
    output logic            branch,
    output logic            jump,
    output logic            jalr,
    output logic            illegal
);
    logic [6:0]      opcode;
    logic [6:0]      funct7;
    logic [4:0]      src1, src2;
    logic [XLEN-1:0] rf_rd1, rf_rd2;
    logic [31:0]     imm32;
    imm_type_e       imm_type;
    ctrl_t           dec, ctrl_q;
    logic            use_rs1, use_rs2;

    assign opcode = instr_in[6:0];
    assign funct7 = instr_in[31:25];
    assign src1   = instr_in[19:15];
    assign src2   = instr_in[24:20];

    regfile #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS_EN(BYPASS_EN)) u_regfile (
        .clk   (clk),
        .reset (reset),
        .ra1   (src1),
        .ra2   (src2),
        .rd1   (rf_rd1),
        .rd2   (rf_rd2),
        .we    (wb_reg_write),
        .wa    (wb_rd),
        .wd    (wb_data)
    );

    always_comb begin
        dec      = '0;
        imm_type = IMM_NONE;
        use_rs1  = 1'b1;
        use_rs2  = 1'b0;
        case (opcode)
            OP: begin
                dec.reg_write = 1'b1;
                dec.alu_op    = alu_from_f3(instr_in[14:12], funct7[5], 1'b1);
                dec.illegal   = (funct7 != 7'h00) && (funct7 != 7'h20);
                use_rs2       = 1'b1;
            end
            OP_IMM: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = alu_from_f3(instr_in[14:12], instr_in[30], 1'b0);
                imm_type      = IMM_I;
            end
            LOAD: begin
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
                dec.alu_src   = 1'b1;
                imm_type      = IMM_I;
            end
            STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                imm_type      = IMM_S;
                use_rs2       = 1'b1;
            end
            BRANCH: begin
                dec.branch = 1'b1;
                dec.alu_op = (instr_in[14:13] == 2'b10) ? ALU_SLT  :
                             (instr_in[14:13] == 2'b11) ? ALU_SLTU : ALU_SUB;
                imm_type   = IMM_B;
                use_rs2    = 1'b1;
            end
            JAL: begin
                dec.reg_write = 1'b1;
                dec.jump      = 1'b1;
                dec.alu_src   = 1'b1;
                imm_type      = IMM_J;
                use_rs1       = 1'b0;
            end
            JALR: begin
                dec.reg_write = 1'b1;
                dec.jump      = 1'b1;
                dec.jalr      = 1'b1;
                dec.alu_src   = 1'b1;
                imm_type      = IMM_I;
            end
            LUI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALU_PASSB;
                imm_type      = IMM_U;
                use_rs1       = 1'b0;
            end
            AUIPC: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                imm_type      = IMM_U;
                use_rs1       = 1'b0;
            end
            default: dec.illegal = 1'b1;
        endcase
        // An illegal instruction must not change architectural state or redirect fetch.
        if (dec.illegal) begin
            dec.reg_write = 1'b0;
            dec.mem_read  = 1'b0;
            dec.mem_write = 1'b0;
            dec.branch    = 1'b0;
            dec.jump      = 1'b0;
        end
    end

    always_comb begin
        imm32 = '0;
        case (imm_type)
            IMM_I:   imm32 = {{20{instr_in[31]}}, instr_in[31:20]};
            IMM_S:   imm32 = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
            IMM_B:   imm32 = {{19{instr_in[31]}}, instr_in[31], instr_in[7],
                              instr_in[30:25], instr_in[11:8], 1'b0};
            IMM_U:   imm32 = {instr_in[31:12], 12'h000};
            IMM_J:   imm32 = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12],
                              instr_in[20], instr_in[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign hazard_stall = in_valid && out_valid && ctrl_q.mem_read && (rd != 5'd0) &&
                          ((use_rs1 && src1 == rd) || (use_rs2 && src2 == rd));

    // Flush, hazard bubbles and invalid input all load the same all-zero ID/EX word.
    always_ff @(posedge clk) begin
        if (!reset || flush || (!stall && (hazard_stall || !in_valid))) begin
            out_valid <= 1'b0;
            pc_out    <= '0;
            rs1_data  <= '0;
            rs2_data  <= '0;
            imm       <= '0;
            rs1       <= '0;
            rs2       <= '0;
            rd        <= '0;
            funct3    <= '0;
            ctrl_q    <= '0;
        end else if (!stall) begin
            out_valid <= 1'b1;
            pc_out    <= pc_in;
            rs1_data  <= rf_rd1;
            rs2_data  <= rf_rd2;
            imm       <= XLEN'($signed(imm32));
            rs1       <= src1;
            rs2       <= src2;
            rd        <= instr_in[11:7];
            funct3    <= instr_in[14:12];
            ctrl_q    <= dec;
        end
    end

    assign reg_write = ctrl_q.reg_write;
    assign mem_read  = ctrl_q.mem_read;
    assign mem_write = ctrl_q.mem_write;
    assign alu_src   = ctrl_q.alu_src;
    assign branch    = ctrl_q.branch;
    assign jump      = ctrl_q.jump;
    assign jalr      = ctrl_q.jalr;
    assign illegal   = ctrl_q.illegal;
    assign alu_op    = ctrl_q.alu_op;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: hand-encoded RV32I instructions with hand-computed results.
module tb_id_stage;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic [31:0]     instr_in;
    logic [XLEN-1:0] pc_in;
    logic            wb_reg_write;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            stall;
    logic            flush;
    logic            hazard_stall;
    logic            out_valid;
    logic [XLEN-1:0] pc_out, rs1_data, rs2_data, imm;
    logic [4:0]      rs1, rs2, rd;
    logic [2:0]      funct3;
    logic [3:0]      alu_op;
    logic            reg_write, mem_read, mem_write, alu_src, branch, jump, jalr, illegal;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] I_ADD_1_5_0   = 32'h000280B3;
    localparam logic [31:0] I_ADDI_2_7_M1 = 32'hFFF38113;
    localparam logic [31:0] I_LW_3_0_1    = 32'h0000A183;
    localparam logic [31:0] I_ADD_4_3_3   = 32'h00318233;
    localparam logic [31:0] I_BEQ_M8      = 32'hFE000CE3;
    localparam logic [31:0] I_ADD_1_0_0   = 32'h000000B3;
    localparam logic [31:0] I_BAD_OPC     = 32'h0000007F;
    localparam logic [31:0] I_MUL_LIKE    = 32'h02000033;
    localparam logic [31:0] I_SRAI_1_2_3  = 32'h40315093;
    localparam logic [31:0] I_LUI_5       = 32'h123452B7;
    localparam logic [31:0] I_SW_5_M4_1   = 32'hFE50AE23;
    localparam logic [31:0] I_JAL_1_16    = 32'h010000EF;

    id_stage #(.XLEN(XLEN), .NREGS(32), .BYPASS_EN(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .instr_in     (instr_in),
        .pc_in        (pc_in),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .stall        (stall),
        .flush        (flush),
        .hazard_stall (hazard_stall),
        .out_valid    (out_valid),
        .pc_out       (pc_out),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .imm          (imm),
        .rs1          (rs1),
        .rs2          (rs2),
        .rd           (rd),
        .funct3       (funct3),
        .alu_op       (alu_op),
        .reg_write    (reg_write),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .alu_src      (alu_src),
        .branch       (branch),
        .jump         (jump),
        .jalr         (jalr),
        .illegal      (illegal)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
        in_valid = 1'b1;
        instr_in = ins;
        pc_in    = pc;
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; instr_in = '0; pc_in = '0;
        wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0; stall = 1'b0; flush = 1'b0;
        tick(); tick();
        check("reset_valid", {31'd0, out_valid}, 32'd0);
        check("reset_pc", pc_out, 32'd0);
        check("reset_regwrite", {31'd0, reg_write}, 32'd0);

        // Write x5, then read it back through a decoded ADD.
        reset = 1'b1;
        wb_reg_write = 1'b1; wb_rd = 5'd5; wb_data = 32'h12345678;
        tick();
        wb_reg_write = 1'b0;
        issue(I_ADD_1_5_0, 32'h100);
        tick();
        check("add_rs1_data", rs1_data, 32'h12345678);
        check("add_alu_op", {28'd0, alu_op}, 32'd0);
        check("add_reg_write", {31'd0, reg_write}, 32'd1);
        check("add_valid", {31'd0, out_valid}, 32'd1);
        check("add_pc", pc_out, 32'h100);
        check("add_rd", {27'd0, rd}, 32'd1);
        check("add_alu_src", {31'd0, alu_src}, 32'd0);

        // Same-cycle writeback forwarded into ADDI.
        wb_reg_write = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEADBEEF;
        issue(I_ADDI_2_7_M1, 32'h104);
        tick();
        wb_reg_write = 1'b0;
        check("bypass_rs1_data", rs1_data, 32'hDEADBEEF);
        check("addi_imm", imm, 32'hFFFFFFFF);
        check("addi_alu_src", {31'd0, alu_src}, 32'd1);

        // Load-use hazard.
        issue(I_LW_3_0_1, 32'h108);
        tick();
        check("lw_mem_read", {31'd0, mem_read}, 32'd1);
        check("lw_rd", {27'd0, rd}, 32'd3);
        issue(I_ADD_4_3_3, 32'h10C);
        #1;
        check("hazard_on", {31'd0, hazard_stall}, 32'd1);
        tick();
        check("bubble_valid", {31'd0, out_valid}, 32'd0);
        check("bubble_mem_read", {31'd0, mem_read}, 32'd0);
        check("hazard_off", {31'd0, hazard_stall}, 32'd0);
        tick();
        check("held_add_valid", {31'd0, out_valid}, 32'd1);
        check("held_add_rd", {27'd0, rd}, 32'd4);
        check("held_add_pc", pc_out, 32'h10C);

        // Branch, then flush.
        issue(I_BEQ_M8, 32'h110);
        tick();
        check("beq_imm", imm, 32'hFFFFFFF8);
        check("beq_branch", {31'd0, branch}, 32'd1);
        check("beq_alu_op", {28'd0, alu_op}, 32'd1);
        check("beq_reg_write", {31'd0, reg_write}, 32'd0);
        flush = 1'b1;
        issue(I_ADD_1_5_0, 32'h114);
        tick();
        flush = 1'b0;
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        check("flush_branch", {31'd0, branch}, 32'd0);
        check("flush_pc", pc_out, 32'd0);

        // Stall holds ID/EX while the input keeps changing.
        issue(I_ADDI_2_7_M1, 32'h200);
        tick();
        check("stored_x7", rs1_data, 32'hDEADBEEF);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue((i == 0) ? I_ADD_1_5_0 : (i == 1) ? I_LW_3_0_1 : I_BEQ_M8, 32'h300 + 32'(4 * i));
            tick();
            check("stall_pc", pc_out, 32'h200);
            check("stall_imm", imm, 32'hFFFFFFFF);
        end
        flush = 1'b1;
        tick();
        check("stall_flush_valid", {31'd0, out_valid}, 32'd0);
        check("stall_flush_pc", pc_out, 32'd0);
        stall = 1'b0; flush = 1'b0;

        // Mid-stream reset clears ID/EX and the register file.
        issue(I_ADD_1_5_0, 32'h400);
        tick();
        check("pre_reset_x5", rs1_data, 32'h12345678);
        reset = 1'b0;
        tick();
        check("mid_reset_valid", {31'd0, out_valid}, 32'd0);
        check("mid_reset_rs1", rs1_data, 32'd0);
        reset = 1'b1;
        tick();
        check("post_reset_x5", rs1_data, 32'd0);
        check("post_reset_valid", {31'd0, out_valid}, 32'd1);

        // x0 stays zero, including through the bypass path.
        wb_reg_write = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
        issue(I_ADD_1_0_0, 32'h500);
        tick();
        wb_reg_write = 1'b0;
        check("x0_bypass", rs1_data, 32'd0);
        tick();
        check("x0_read", rs1_data, 32'd0);

        // Illegal encodings.
        issue(I_BAD_OPC, 32'h504);
        tick();
        check("badopc_illegal", {31'd0, illegal}, 32'd1);
        check("badopc_reg_write", {31'd0, reg_write}, 32'd0);
        issue(I_MUL_LIKE, 32'h508);
        tick();
        check("funct7_illegal", {31'd0, illegal}, 32'd1);
        check("funct7_reg_write", {31'd0, reg_write}, 32'd0);

        // Remaining immediate formats and alu_op selections.
        issue(I_SRAI_1_2_3, 32'h50C);
        tick();
        check("srai_alu_op", {28'd0, alu_op}, 32'd7);
        check("srai_illegal", {31'd0, illegal}, 32'd0);
        issue(I_LUI_5, 32'h510);
        tick();
        check("lui_imm", imm, 32'h12345000);
        check("lui_alu_op", {28'd0, alu_op}, 32'd10);
        issue(I_SW_5_M4_1, 32'h514);
        tick();
        check("sw_imm", imm, 32'hFFFFFFFC);
        check("sw_mem_write", {31'd0, mem_write}, 32'd1);
        check("sw_rs2", {27'd0, rs2}, 32'd5);
        issue(I_JAL_1_16, 32'h518);
        tick();
        check("jal_imm", imm, 32'h00000010);
        check("jal_jump", {31'd0, jump}, 32'd1);
        check("jal_jalr", {31'd0, jalr}, 32'd0);

        in_valid = 1'b0;
        tick();
        check("invalid_bubble", {31'd0, out_valid}, 32'd0);
        check("invalid_reg_write", {31'd0, reg_write}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Parametrised successor to the combinational decode stage.
- Full RV32I decoder, XLEN-wide register file with write-through bypass, registered ID/EX pipeline outputs with a valid bit, and load-use hazard detection.
- Sits between the IF/ID register and the execute stage.
- Replaces ad-hoc stall/flush handling with defined bubble insertion.

Parameters:
- XLEN, 32, datapath and register width.
- NREGS, 32, architectural register count; must be a power of 2, at most 32. Register index width is log2(NREGS).
- BYPASS_EN, 1, when 1, a same-cycle writeback to a source register is forwarded into rs1_data/rs2_data.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset: state clears on a rising clk edge while reset==0.
- in_valid  in  1  instr_in/pc_in carry a real instruction.
- instr_in  in  32  instruction from IF/ID.
- pc_in  in  XLEN  PC of instr_in.
- wb_reg_write  in  1  writeback enable.
- wb_rd  in  5  writeback destination.
- wb_data  in  XLEN  writeback value.
- stall  in  1  downstream stall; hold ID/EX.
- flush  in  1  kill the ID/EX contents (branch redirect).
- hazard_stall  out  1  combinational; load-use detected, fetch and IF/ID must hold.
- out_valid  out  1  registered.
- pc_out  out  XLEN  registered.
- rs1_data, rs2_data  out  XLEN each  registered.
- imm  out  XLEN  registered.
- rs1, rs2, rd  out  5 each  registered.
- funct3  out  3  registered.
- alu_op  out  4  registered.
- Control bits, each out 1, registered: reg_write, mem_read, mem_write, alu_src, branch, jump, jalr, illegal.

Behaviour:
- Reset (reset==0 at a clk edge): all registered outputs go to 0, all NREGS registers go to 0. Reset overrides stall and flush. Reset asserted mid-operation discards any in-flight instruction.
- Register file:
  - Written at the clk edge when wb_reg_write && wb_rd!=0.
  - A write to x0 is ignored. Reads of x0 return 0.
  - wb_rd >= NREGS is ignored.
- Read data: combinational read of instr_in[19:15] and [24:20], latched into ID/EX.
  - BYPASS_EN=1 and a same-cycle write to that index (nonzero): wb_data is latched.
  - BYPASS_EN=0: the old register value is latched.
- Latency: 1 cycle from instr_in to the ID/EX outputs.
- Immediate formats, sign-extended to XLEN:
  - I: OP-IMM, LOAD, JALR.
  - S: STORE.
  - B: BRANCH, bit0=0.
  - U: LUI, AUIPC, low 12 bits 0.
  - J: JAL, bit0=0.
- alu_op encodings (package): ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, PASSB=10.
  - OP: funct7[5] selects SUB/SRA.
  - OP-IMM: SRAI is selected by imm[10]. SUBI does not exist, so funct7[5] with funct3=000 means ADD.
  - BRANCH: SUB for BEQ/BNE, SLT for BLT/BGE, SLTU for BLTU/BGEU.
  - LUI: PASSB. AUIPC, JAL, JALR, LOAD, STORE: ADD.
- illegal=1: unknown opcode, or OP with funct7 not 0000000/0100000. For illegal instructions reg_write, mem_read, mem_write, branch and jump are all 0.
- Source-use rules:
  - rs1 is used by everything except LUI, AUIPC and JAL.
  - rs2 is used by OP, STORE and BRANCH.
  - rd is written by OP, OP-IMM, LOAD, LUI, AUIPC, JAL and JALR.
- hazard_stall = in_valid & out_valid & mem_read(out) & rd(out)!=0 & ((rs1 used & rs1==rd(out)) | (rs2 used & rs2==rd(out))).
- ID/EX update priority, highest first:
  1. reset.
  2. flush: out_valid=0, all control bits 0, pc_out=0, data fields 0.
  3. stall: hold all outputs.
  4. hazard_stall: load a bubble (same as flush); the upstream instruction is held by fetch.
  5. Otherwise load the decoded instruction, with out_valid=in_valid.
- in_valid=0 loads a bubble with all control bits 0.
- hazard_stall is computed even while stall=1, but has no effect on ID/EX during stall.

Decomposition:
- Shared package rv_pkg:
  - Opcode localparams: OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
  - alu_op constants.
  - Immediate-type enum.
- One sub-module, regfile (parameters XLEN, NREGS, BYPASS_EN): 2 read ports, 1 write port, x0 hardwired.
- Decode logic and the ID/EX register stay in id_stage.

Test Plan:
- Write x5=0x12345678 via wb, then decode ADD x1,x5,x0 → next cycle rs1_data=0x12345678, alu_op=0, reg_write=1, out_valid=1.
- Same-cycle wb x7=0xDEADBEEF while decoding ADDI x2,x7,-1 (BYPASS_EN=1) → rs1_data=0xDEADBEEF, imm=0xFFFFFFFF, alu_src=1.
- LW x3,0(x1) in ID/EX, then ADD x4,x3,x3 at input → hazard_stall=1; next cycle out_valid=0, mem_read=0. With the instruction held, the following cycle decodes the ADD.
- BEQ with offset -8 (instr 0xFE000CE3) → imm=0xFFFFFFF8, branch=1, alu_op=SUB; then flush=1 → next cycle out_valid=0, branch=0, pc_out=0.
- stall=1 for 3 cycles with changing instr_in → outputs unchanged. flush and stall together → bubble. reset=0 mid-stream → all outputs 0 and x5 reads 0 afterwards.
- wb to x0 with data 0xFFFFFFFF, then ADD x1,x0,x0 → rs1_data=0. Opcode 0x7F → illegal=1, reg_write=0.
